// File: rtl/output_port_arbiter.sv
// Round-robin arbiter popping one packet per grant from the output-port FIFOs
// and holding it in a registered valid/ack channel toward the BFT switch.

module output_port_arbiter_lane #(
  parameter int PTR_BITS = 3,
  parameter int IDX      = 0
) (
  input  logic                empty,
  input  logic [PTR_BITS-1:0] rr_ptr,
  output logic                req,
  output logic                req_hi
);
  localparam logic [PTR_BITS-1:0] IDX_P = PTR_BITS'(IDX);

  // req_hi marks ports at or after the pointer; they win over wrapped-around ports
  assign req    = ~empty;
  assign req_hi = ~empty & (IDX_P >= rr_ptr);
endmodule

module output_port_arbiter #(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_OUT_PORTS = 7
) (
  input  logic                               clk_bft,
  input  logic                               reset_bft,
  input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0] internal_out,
  input  logic [NUM_OUT_PORTS-1:0]           empty,
  output logic [NUM_OUT_PORTS-1:0]           rd_en_sel,
  output logic [PACKET_BITS-1:0]             dout_leaf_interface2bft,
  output logic                               vld_interface2bft,
  input  logic                               ack_bft2interface,
  output logic [31:0]                        pkt_sent_cnt
);
  localparam int PTR_BITS = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                   state, state_d;
  logic [PTR_BITS-1:0]                      rr_ptr, grant_idx, ptr_nxt;
  logic [NUM_OUT_PORTS-1:0]                 req, req_hi;
  logic [NUM_OUT_PORTS-1:0][PACKET_BITS-1:0] pkts;
  logic                                     found, can_load, do_grant;
  logic [PACKET_BITS-1:0]                   dout_q;
  logic                                     vld_q;
  logic [31:0]                              cnt_q;

  assign pkts = internal_out;

  for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_lane
    output_port_arbiter_lane #(.PTR_BITS(PTR_BITS), .IDX(i)) u_lane (
      .empty  (empty[i]),
      .rr_ptr (rr_ptr),
      .req    (req[i]),
      .req_hi (req_hi[i])
    );
  end

  // Lowest ready index at/after the pointer, else lowest ready index overall
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (req_hi[i] && !found) begin
        grant_idx = PTR_BITS'(i);
        found     = 1'b1;
      end
    end
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      if (req[i] && !found) begin
        grant_idx = PTR_BITS'(i);
        found     = 1'b1;
      end
    end
  end

  assign ptr_nxt = (grant_idx == PTR_BITS'(NUM_OUT_PORTS - 1)) ? '0 : grant_idx + 1'b1;

  always_comb begin
    state_d   = state;
    can_load  = (state == IDLE) | ack_bft2interface;
    do_grant  = can_load & (|req) & ~reset_bft;
    rd_en_sel = '0;
    if (do_grant) begin
      rd_en_sel = NUM_OUT_PORTS'(1) << grant_idx;
      state_d   = SEND;
    end else if (state == SEND && ack_bft2interface) begin
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk_bft or posedge reset_bft) begin
    if (reset_bft) state <= IDLE;
    else           state <= state_d;
  end

  always_ff @(posedge clk_bft or posedge reset_bft) begin
    if (reset_bft) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
      rr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (vld_q && ack_bft2interface) cnt_q <= cnt_q + 32'd1;
      if (do_grant) begin
        dout_q <= pkts[grant_idx];
        vld_q  <= 1'b1;
        rr_ptr <= ptr_nxt;
      end else if (vld_q && ack_bft2interface) begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign dout_leaf_interface2bft = dout_q;
  assign vld_interface2bft       = vld_q;
  assign pkt_sent_cnt            = cnt_q;
endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: FWFT FIFO queues feed the DUT and a
// queue-level round-robin model predicts grants, output packet and count.

module tb_output_port_arbiter;
  localparam int PB = 97;
  localparam int NP = 7;
  typedef logic [PB-1:0] pkt_t;

  logic             clk_bft = 1'b0;
  logic             reset_bft;
  logic             ack;
  logic [PB*NP-1:0] internal_out;
  logic [NP-1:0]    empty, rd_en_sel;
  logic [PB-1:0]    dout;
  logic             vld;
  logic [31:0]      cnt;

  output_port_arbiter #(.PACKET_BITS(PB), .NUM_OUT_PORTS(NP)) dut (
    .clk_bft                 (clk_bft),
    .reset_bft               (reset_bft),
    .internal_out            (internal_out),
    .empty                   (empty),
    .rd_en_sel               (rd_en_sel),
    .dout_leaf_interface2bft (dout),
    .vld_interface2bft       (vld),
    .ack_bft2interface       (ack),
    .pkt_sent_cnt            (cnt)
  );

  always #5 clk_bft = ~clk_bft;

  pkt_t        q [NP][$];
  int          n_vec = 0;
  int          n_err = 0;
  logic        m_vld;
  pkt_t        m_dout;
  int          m_ptr;
  logic [31:0] m_cnt;
  pkt_t        p2, p5;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_dout = '0;
    m_ptr  = 0;
    m_cnt  = '0;
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NP; k++) begin
      if (q[(m_ptr + k) % NP].size() != 0) return (m_ptr + k) % NP;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      empty[i] = (q[i].size() == 0);
      internal_out[PB*i +: PB] = (q[i].size() != 0) ? q[i][0] : '0;
    end
    #1;
  endtask

  // One clock: compare before the edge, then advance model and FIFOs
  task automatic tick();
    int            g;
    logic [NP-1:0] exp_rd, pop_mask;
    drive();
    @(negedge clk_bft);
    g      = model_grant();
    exp_rd = '0;
    if ((!m_vld || ack) && g >= 0 && !reset_bft) exp_rd[g] = 1'b1;
    chk("rd_en_sel", 128'(rd_en_sel), 128'(exp_rd));
    chk("vld", 128'(vld), 128'(m_vld));
    chk("dout", 128'(dout), 128'(m_dout));
    chk("pkt_sent_cnt", 128'(cnt), 128'(m_cnt));
    pop_mask = rd_en_sel;
    @(posedge clk_bft);
    if (reset_bft) model_reset();
    else begin
      if (m_vld && ack) m_cnt = m_cnt + 32'd1;
      if (exp_rd != '0) begin
        m_dout = q[g][0];
        m_vld  = 1'b1;
        m_ptr  = (g + 1) % NP;
      end else if (m_vld && ack) m_vld = 1'b0;
    end
    for (int i = 0; i < NP; i++)
      if (pop_mask[i] && q[i].size() != 0) void'(q[i].pop_front());
    #1;
  endtask

  task automatic do_reset();
    reset_bft = 1'b1;
    #1;
    for (int i = 0; i < NP; i++) q[i].delete();
    model_reset();
    repeat (2) tick();
    @(negedge clk_bft);
    reset_bft = 1'b0;
    @(posedge clk_bft);
    #1;
  endtask

  initial begin
    logic [NP-1:0] oh;
    reset_bft = 1'b1;
    ack       = 1'b0;
    model_reset();
    drive();
    do_reset();

    // Idle with all ports empty; ack without vld is ignored
    for (int k = 0; k < 20; k++) begin
      ack = (k >= 10);
      tick();
    end
    chk("idle cnt", 128'(cnt), 128'(32'd0));
    chk("idle vld", 128'(vld), 128'(1'b0));

    // Single packet on port 3
    ack = 1'b1;
    q[3].push_back(pkt_t'(32'h1ABC));
    drive();
    chk("single rd", 128'(rd_en_sel), 128'(7'b0001000));
    tick();
    chk("single vld", 128'(vld), 128'(1'b1));
    chk("single dout", 128'(dout), 128'(32'h1ABC));
    tick();
    chk("single vld drop", 128'(vld), 128'(1'b0));
    chk("single cnt", 128'(cnt), 128'(32'd1));

    // All ports with two packets: full rate, strict rotation
    do_reset();
    ack = 1'b1;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 2; k++) q[p].push_back(pkt_t'(32'hA000 + 32'h100 * p + k));
    for (int k = 0; k < 14; k++) begin
      drive();
      oh = NP'(1) << (k % NP);
      chk("rotation rd", 128'(rd_en_sel), 128'(oh));
      tick();
      chk("rotation vld", 128'(vld), 128'(1'b1));
    end
    tick();
    chk("rotation cnt", 128'(cnt), 128'(32'd14));
    chk("rotation drain", 128'(vld), 128'(1'b0));

    // Backpressure with ports 2 and 5 loaded
    do_reset();
    ack = 1'b0;
    p2  = pkt_t'(32'h2222_0002);
    p5  = pkt_t'(32'h5555_0005);
    q[2].push_back(p2);
    q[5].push_back(p5);
    tick();
    chk("bp first", 128'(dout), 128'(p2));
    for (int k = 0; k < 10; k++) begin
      drive();
      chk("bp rd idle", 128'(rd_en_sel), 128'(7'b0));
      tick();
      chk("bp hold", 128'(dout), 128'(p2));
    end
    ack = 1'b1;
    tick();
    chk("bp next", 128'(dout), 128'(p5));
    chk("bp cnt", 128'(cnt), 128'(32'd1));
    tick();
    chk("bp cnt2", 128'(cnt), 128'(32'd2));

    // Fairness: pointer at 6, ports 0 and 6 compete, port 6 refilled
    q[0].push_back(pkt_t'(32'hF000));
    q[6].push_back(pkt_t'(32'hF6A));
    drive();
    chk("fair rd6", 128'(rd_en_sel), 128'(7'b1000000));
    tick();
    q[6].push_back(pkt_t'(32'hF6B));
    drive();
    chk("fair rd0", 128'(rd_en_sel), 128'(7'b0000001));
    tick();
    chk("fair dout0", 128'(dout), 128'(32'hF000));
    drive();
    chk("fair rd6b", 128'(rd_en_sel), 128'(7'b1000000));
    tick();
    q[6].push_back(pkt_t'(32'hF6C));
    drive();
    chk("single port repeat", 128'(rd_en_sel), 128'(7'b1000000));
    tick();
    chk("fair dout6c", 128'(dout), 128'(32'hF6C));
    tick();

    // Counter wrap
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    chk("cnt preload", 128'(cnt), 128'(32'hFFFF_FFFF));
    q[1].push_back(pkt_t'(32'h1111));
    tick();
    tick();
    chk("cnt wrap", 128'(cnt), 128'(32'd0));

    // Reset while holding a packet
    ack = 1'b0;
    q[4].push_back(pkt_t'(32'h4444));
    tick();
    chk("pre-reset vld", 128'(vld), 128'(1'b1));
    reset_bft = 1'b1;
    #1;
    chk("async vld", 128'(vld), 128'(1'b0));
    chk("async dout", 128'(dout), 128'(0));
    do_reset();
    tick();
    chk("post-reset vld", 128'(vld), 128'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
